// File: rtl/burst_bus_initiator_if.sv
// Burst bus carrying one address/data beat per handshake from an initiator to the fabric.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are both 1.
// While valid=1 and ready=0, the initiator holds valid, addr, data, last and burst_type
// unchanged. valid never falls without a transfer. ready may change freely.
// last marks the final beat of a burst.
interface burst_bus_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
    logic [2:0]        burst_type;

    modport master (output valid, output addr, output data, output last, output burst_type,
                    input ready);
    modport slave  (input valid, input addr, input data, input last, input burst_type,
                    output ready);
endinterface

// File: rtl/burst_bus_initiator.sv
// Burst bus initiator: a write-data FIFO feeds beats onto the bus for commands
// accepted on a command handshake, with FIXED/INCR/WRAP address generation.
module burst_bus_initiator #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [7:0]             cmd_len,
    input  logic [2:0]             cmd_burst,
    output logic                   cmd_err,
    burst_bus_initiator_if.master  bus,
    output logic                   busy,
    output logic                   dbg_state
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [2:0] FIXED = 3'b000;
    localparam logic [2:0] INCR  = 3'b001;
    localparam logic [2:0] WRAP  = 3'b010;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count_next;
    logic [8:0]        beats_left;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] wrap_mask;

    logic              push_ok, accept, cmd_illegal, start, can_load, fin;
    logic [8:0]        ld_beats;
    logic [ADDR_W-1:0] ld_addr, ld_mask, cmd_wrap_mask, next_addr;
    logic [2:0]        ld_type;

    assign dbg_state = (state == BURST);

    // Command decode and the parameters of the beat that may load this cycle
    always_comb begin
        push_ok       = push && !full;
        accept        = cmd_valid && cmd_ready;
        cmd_illegal   = (cmd_burst > WRAP) ||
                        ((cmd_burst == WRAP) && !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                        ((cmd_burst == WRAP) && (cmd_addr[1:0] != 2'b00));
        start         = accept && !cmd_illegal;
        // Wrap boundary minus one: 4*(len+1)-1
        cmd_wrap_mask = {{(ADDR_W-10){1'b0}}, cmd_len, 2'b11};
        // In the acceptance cycle the first beat comes straight from the command
        ld_beats      = start ? ({1'b0, cmd_len} + 9'd1) : beats_left;
        ld_addr       = start ? cmd_addr : cur_addr;
        ld_type       = start ? cmd_burst : bus.burst_type;
        ld_mask       = start ? cmd_wrap_mask : wrap_mask;
        can_load      = ((state == BURST) || start) && (!bus.valid || bus.ready) &&
                        (ld_beats != 9'd0) && !empty;
        fin           = bus.valid && bus.ready && bus.last;
        case (ld_type)
            INCR:    next_addr = (ld_addr & ~ADDR_W'(3)) + ADDR_W'(4);
            WRAP:    next_addr = (ld_addr & ~ld_mask) | ((ld_addr + ADDR_W'(4)) & ld_mask);
            default: next_addr = ld_addr;
        endcase
        case ({push_ok, can_load})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // FIFO storage; contents need no reset because occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    // FIFO pointers, occupancy and registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_ok)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (can_load) rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_next;
            full     <= (count_next == FULL_CNT);
            empty    <= (count_next == '0);
            overflow <= push && full;
        end
    end

    // Command FSM and beat generation with registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cmd_ready      <= 1'b1;
            cmd_err        <= 1'b0;
            busy           <= 1'b0;
            beats_left     <= '0;
            cur_addr       <= '0;
            wrap_mask      <= '0;
            bus.valid      <= 1'b0;
            bus.last       <= 1'b0;
            bus.addr       <= '0;
            bus.data       <= '0;
            bus.burst_type <= '0;
        end else begin
            cmd_err <= accept && cmd_illegal;
            case (state)
                IDLE: begin
                    // Any accepted command, legal or not, closes cmd_ready for a cycle
                    cmd_ready <= !accept;
                    if (start) begin
                        state          <= BURST;
                        busy           <= 1'b1;
                        bus.burst_type <= cmd_burst;
                        wrap_mask      <= cmd_wrap_mask;
                    end
                end
                default: begin
                    if (fin) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
            endcase
            if (can_load) begin
                bus.valid  <= 1'b1;
                bus.addr   <= ld_addr;
                bus.data   <= mem[rd_ptr];
                bus.last   <= (ld_beats == 9'd1);
                beats_left <= ld_beats - 9'd1;
                cur_addr   <= next_addr;
            end else begin
                // FIFO ran dry at acceptance: remember the burst, load later
                if (start) begin
                    beats_left <= ld_beats;
                    cur_addr   <= cmd_addr;
                end
                if (bus.valid && bus.ready) begin
                    bus.valid <= 1'b0;
                    bus.last  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_burst_bus_initiator.sv
// Directed bench for burst_bus_initiator: FIFO behaviour, the three burst types,
// illegal command rejection, back-pressure hold and reset mid-burst.
module tb_burst_bus_initiator;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              push;
    logic [DATA_W-1:0] wr_data;
    logic              full, empty, overflow;
    logic [4:0]        count;
    logic              cmd_valid, cmd_ready, cmd_err;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic [2:0]        cmd_burst;
    logic              busy, dbg_state;

    burst_bus_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    burst_bus_initiator #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_burst(cmd_burst), .cmd_err(cmd_err),
        .bus(bus_if), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic        ovf_seen = 1'b0;
    logic [31:0] hs_addr[$], hs_data[$];
    logic        hs_last[$];
    int          hs_cyc[$];
    logic [31:0] exp_addr_q[$], exp_data_q[$];
    logic        exp_last_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitor: values at the negedge are those the next posedge samples
    always @(negedge clk) begin
        if (rst_n && bus_if.valid && bus_if.ready) begin
            hs_addr.push_back(bus_if.addr);
            hs_data.push_back(bus_if.data);
            hs_last.push_back(bus_if.last);
            hs_cyc.push_back(cyc);
        end
        if (overflow) ovf_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_beats();
        hs_addr.delete(); hs_data.delete(); hs_last.delete(); hs_cyc.delete();
        exp_addr_q.delete(); exp_data_q.delete(); exp_last_q.delete();
    endtask

    task automatic expect_beat(input logic [31:0] a, input logic [31:0] d, input logic l);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
        exp_last_q.push_back(l);
    endtask

    task automatic push_word(input logic [31:0] d);
        push = 1'b1;
        wr_data = d;
        tick();
        push = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [7:0] len, input logic [2:0] b);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_burst = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int c = 0;
        while (hs_addr.size() < n && c < budget) begin
            tick();
            c++;
        end
        check($sformatf("%s_beat_count", tag), hs_addr.size(), n);
    endtask

    task automatic check_beats(input string tag, input logic consec);
        for (int i = 0; i < exp_addr_q.size(); i++) begin
            if (i < hs_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), hs_addr[i], exp_addr_q[i]);
                check($sformatf("%s_data%0d", tag, i), hs_data[i], exp_data_q[i]);
                check($sformatf("%s_last%0d", tag, i), hs_last[i], exp_last_q[i]);
                if (consec && i > 0)
                    check($sformatf("%s_gap%0d", tag, i), hs_cyc[i] - hs_cyc[i-1], 1);
            end
        end
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pushed;
        int c;
        rst_n = 1'b0; push = 1'b0; wr_data = '0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_burst = '0;
        bus_if.ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", bus_if.valid, 0);
        check("rst_last", bus_if.last, 0);
        check("rst_addr", bus_if.addr, 0);
        check("rst_data", bus_if.data, 0);
        check("rst_btype", bus_if.burst_type, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        tick();

        // INCR 4 beats, back-to-back
        clear_beats();
        bus_if.ready = 1'b1;
        push_word(32'h0000_0000);
        push_word(32'hFFFF_FFFF);
        push_word(32'hAAAA_AAAA);
        push_word(32'h5555_5555);
        check("t1_count", count, 4);
        send_cmd(32'h100, 8'd3, 3'b001);
        check("t1_first_valid", bus_if.valid, 1);
        check("t1_busy", busy, 1);
        check("t1_cmd_ready_low", cmd_ready, 0);
        check("t1_btype", bus_if.burst_type, 3'b001);
        expect_beat(32'h100, 32'h0000_0000, 1'b0);
        expect_beat(32'h104, 32'hFFFF_FFFF, 1'b0);
        expect_beat(32'h108, 32'hAAAA_AAAA, 1'b0);
        expect_beat(32'h10C, 32'h5555_5555, 1'b1);
        wait_beats("t1", 4, 20);
        check_beats("t1", 1'b1);
        check("t1_cmd_ready_after", cmd_ready, 1);
        check("t1_valid_after", bus_if.valid, 0);
        check("t1_busy_after", busy, 0);
        check("t1_empty_after", empty, 1);

        // WRAP 16-byte window starting mid-window
        clear_beats();
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        push_word(32'h3333_3333);
        push_word(32'h4444_4444);
        send_cmd(32'h38, 8'd3, 3'b010);
        expect_beat(32'h38, 32'h1111_1111, 1'b0);
        expect_beat(32'h3C, 32'h2222_2222, 1'b0);
        expect_beat(32'h30, 32'h3333_3333, 1'b0);
        expect_beat(32'h34, 32'h4444_4444, 1'b1);
        wait_beats("t2", 4, 20);
        check_beats("t2", 1'b1);

        // Illegal commands: bad WRAP length, misaligned WRAP, reserved burst type
        clear_beats();
        push_word(32'h0BAD_0001);
        send_cmd(32'h38, 8'd2, 3'b010);
        check("t2_len_err", cmd_err, 1);
        check("t2_len_ready", cmd_ready, 0);
        check("t2_len_valid", bus_if.valid, 0);
        check("t2_len_busy", busy, 0);
        tick();
        check("t2_err_pulse", cmd_err, 0);
        check("t2_ready_back", cmd_ready, 1);
        send_cmd(32'h3A, 8'd3, 3'b010);
        check("t2_align_err", cmd_err, 1);
        tick();
        send_cmd(32'h40, 8'd0, 3'b011);
        check("t2_rsv_err", cmd_err, 1);
        tick();
        check("t2_no_beats", hs_addr.size(), 0);
        check("t2_count_kept", count, 1);

        // INCR across the top of the address space
        clear_beats();
        push_word(32'h1234_5678);
        send_cmd(32'hFFFF_FFFC, 8'd1, 3'b001);
        expect_beat(32'hFFFF_FFFC, 32'h0BAD_0001, 1'b0);
        expect_beat(32'h0000_0000, 32'h1234_5678, 1'b1);
        wait_beats("t3", 2, 20);
        check_beats("t3", 1'b1);

        // Single FIXED beat held under back-pressure
        clear_beats();
        bus_if.ready = 1'b0;
        push_word(32'hDEAD_BEEF);
        send_cmd(32'h200, 8'd0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_valid%0d", i), bus_if.valid, 1);
            check($sformatf("t4_addr%0d", i), bus_if.addr, 32'h200);
            check($sformatf("t4_data%0d", i), bus_if.data, 32'hDEAD_BEEF);
            check($sformatf("t4_last%0d", i), bus_if.last, 1);
            if (i < 3) tick();
        end
        check("t4_no_hs_yet", hs_addr.size(), 0);
        bus_if.ready = 1'b1;
        tick();
        expect_beat(32'h200, 32'hDEAD_BEEF, 1'b1);
        check("t4_beat_count", hs_addr.size(), 1);
        check_beats("t4", 1'b0);
        check("t4_valid_after", bus_if.valid, 0);
        check("t4_cmd_ready_after", cmd_ready, 1);

        // Fill to full, overflow on the 17th push
        clear_beats();
        for (int i = 0; i < 16; i++) push_word(32'h100 + i);
        check("t5_count_full", count, 16);
        check("t5_full", full, 1);
        check("t5_not_empty", empty, 0);
        check("t5_no_ovf_yet", overflow, 0);
        push_word(32'h00BA_DBAD);
        check("t5_overflow", overflow, 1);
        check("t5_count_kept", count, 16);
        tick();
        check("t5_ovf_pulse", overflow, 0);

        // 256-beat INCR with the producer pushing whenever there is room
        ovf_seen = 1'b0;
        for (int i = 0; i < 256; i++) expect_beat(32'h1000 + 4 * i, 32'h100 + i, i == 255);
        cmd_valid = 1'b1; cmd_addr = 32'h1000; cmd_len = 8'd255; cmd_burst = 3'b001;
        pushed = 16;
        c = 0;
        while (hs_addr.size() < 256 && c < 2000) begin
            tick();
            c++;
            cmd_valid = 1'b0;
            if (pushed < 256 && !full) begin
                push = 1'b1;
                wr_data = 32'h100 + pushed;
                pushed++;
            end else begin
                push = 1'b0;
            end
        end
        push = 1'b0;
        check("t5_beat_count", hs_addr.size(), 256);
        check_beats("t5", 1'b1);
        check("t5_no_overflow", ovf_seen, 0);
        check("t5_cmd_ready_after", cmd_ready, 1);

        // Reset after 2 of 8 beats, then a fresh command
        clear_beats();
        for (int i = 0; i < 8; i++) push_word(32'hA0 + i);
        send_cmd(32'h2000, 8'd7, 3'b001);
        wait_beats("t6_pre", 2, 20);
        rst_n = 1'b0;
        #1;
        check("t6_valid", bus_if.valid, 0);
        check("t6_count", count, 0);
        check("t6_empty", empty, 1);
        check("t6_cmd_ready", cmd_ready, 1);
        check("t6_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        clear_beats();
        push_word(32'h77);
        push_word(32'h88);
        send_cmd(32'h300, 8'd1, 3'b000);
        expect_beat(32'h300, 32'h77, 1'b0);
        expect_beat(32'h300, 32'h88, 1'b1);
        wait_beats("t6", 2, 20);
        check_beats("t6", 1'b1);
        check("t6_cmd_ready_after", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
